i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 134 +++++++++++++
 tb/tb_i2c_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: two-requester round-robin front end for a single I2C master.
// A granted request is latched into the m_* command fields, issued with a
// one-cycle m_start, and then waited on until m_done arrives or the WAIT
// counter reaches its terminal count. The result goes back to the owning
// requester as a one-cycle rsp_done pulse.
module i2c_arbiter #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [13:0] req_addr,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_done,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_nack,
  output logic        timeout,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [7:0]  m_wdata,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic [7:0]  m_rdata,
  input  logic        m_nack
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int              CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   TERM = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          last_grant;
  logic          owner;
  logic [CW-1:0] count;
  logic [7:0]    res_rdata;
  logic          res_nack;
  logic          res_timeout;
  logic          sel;
  logic          handshake;

  // Pick the requester to offer ready to: the sole valid one, or on a tie
  // the one that did not win last time.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch.
    sel       = 1'b0;
    req_ready = 2'b00;
    if (req_valid == 2'b11) sel = ~last_grant;
    else                    sel = req_valid[1];
    if (!reset && state == IDLE && !m_busy && req_valid[sel])
      req_ready = sel ? 2'b10 : 2'b01;
  end

  assign handshake = |req_ready;

  // Outputs decoded from the state so they are exactly one cycle wide and
  // fall to zero the moment reset forces the state back to IDLE.
  always_comb begin
    m_start   = (state == ISSUE);
    rsp_done  = 2'b00;
    rsp_rdata = 8'h00;
    rsp_nack  = 1'b0;
    timeout   = 1'b0;
    if (state == RESP) begin
      rsp_done  = owner ? 2'b10 : 2'b01;
      rsp_rdata = res_rdata;
      rsp_nack  = res_nack;
      timeout   = res_timeout;
    end
  end

  // Transaction sequencer: grant, issue, wait for completion or timeout,
  // respond, then return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the register set is small, so every register is reset; this
    // also guarantees an abandoned transaction leaves nothing behind.
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      count       <= '0;
      res_rdata   <= 8'h00;
      res_nack    <= 1'b0;
      res_timeout <= 1'b0;
      m_addr      <= 7'h00;
      m_rw        <= 1'b0;
      m_wdata     <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments keep every register update in step.
      case (state)
        IDLE: begin
          if (handshake) begin
            m_addr  <= sel ? req_addr[13:7]   : req_addr[6:0];
            m_rw    <= sel ? req_rw[1]        : req_rw[0];
            m_wdata <= sel ? req_wdata[15:8]  : req_wdata[7:0];
            owner   <= sel;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (m_done) begin
            res_rdata   <= m_rdata;
            res_nack    <= m_nack;
            res_timeout <= 1'b0;
            state       <= RESP;
          end else if (count == TERM) begin
            res_rdata   <= 8'h00;
            res_nack    <= 1'b1;
            res_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            count <= count + 1'b1;
          end
        end
        RESP: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed and randomized transactions against a
// transaction-level model of the arbiter (round-robin winner, completion
// cycle derived from the m_done delay versus the timeout window).
module tb_i2c_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [13:0] req_addr = '0;
  logic [1:0]  req_rw = '0;
  logic [15:0] req_wdata = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [7:0]  m_rdata = 8'h00;
  logic        m_nack = 1'b0;

  logic [1:0] a_ready, a_done, b_ready, b_done;
  logic [7:0] a_rdata, b_rdata, a_wdata, b_wdata;
  logic [6:0] a_addr, b_addr;
  logic       a_nack, b_nack, a_to, b_to, a_start, b_start, a_rw, b_rw;

  // Instance a: long window (64); instance b: TIMEOUT=16 for timeout tests.
  i2c_arbiter #(.TIMEOUT(64)) u_dut64 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata), .req_ready(a_ready),
    .rsp_done(a_done), .rsp_rdata(a_rdata), .rsp_nack(a_nack),
    .timeout(a_to), .m_start(a_start), .m_addr(a_addr), .m_rw(a_rw),
    .m_wdata(a_wdata), .m_busy(m_busy), .m_done(m_done),
    .m_rdata(m_rdata), .m_nack(m_nack));

  i2c_arbiter #(.TIMEOUT(16)) u_dut16 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata), .req_ready(b_ready),
    .rsp_done(b_done), .rsp_rdata(b_rdata), .rsp_nack(b_nack),
    .timeout(b_to), .m_start(b_start), .m_addr(b_addr), .m_rw(b_rw),
    .m_wdata(b_wdata), .m_busy(m_busy), .m_done(m_done),
    .m_rdata(m_rdata), .m_nack(m_nack));

  always #5 clk = ~clk;

  // Instance under observation.
  logic use16 = 1'b0;
  wire [1:0] o_ready = use16 ? b_ready : a_ready;
  wire [1:0] o_done  = use16 ? b_done  : a_done;
  wire [7:0] o_rdata = use16 ? b_rdata : a_rdata;
  wire       o_nack  = use16 ? b_nack  : a_nack;
  wire       o_to    = use16 ? b_to    : a_to;
  wire       o_start = use16 ? b_start : a_start;
  wire [6:0] o_addr  = use16 ? b_addr  : a_addr;
  wire       o_rw    = use16 ? b_rw    : a_rw;
  wire [7:0] o_wdata = use16 ? b_wdata : a_wdata;

  int checks = 0;
  int errors = 0;

  // Model state and requester fields.
  logic       model_lg;
  logic [6:0] f_addr  [2];
  logic       f_rw    [2];
  logic [7:0] f_wdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 2; i++) begin
      f_addr[i]  = 7'($urandom_range(0, 127));
      f_rw[i]    = 1'($urandom_range(0, 1));
      f_wdata[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 2'b01; m_busy = 1'b0; m_done = 1'b0;
    @(negedge clk);
    check("rst_ready_a", a_ready, 2'b00);
    check("rst_ready_b", b_ready, 2'b00);
    check("rst_out_a", {a_done, a_rdata, a_nack, a_to, a_start}, '0);
    check("rst_cmd_a", {a_addr, a_rw, a_wdata}, '0);
    check("rst_out_b", {b_done, b_rdata, b_nack, b_to, b_start}, '0);
    tick();
    reset = 1'b0; req_valid = 2'b00;
    model_lg = 1'b1;
  endtask

  // One transaction. Fields come from f_*; m_done is raised in WAIT cycle
  // 'delay' (0 = WAIT entry cycle), never if delay >= window.
  task automatic do_txn(input logic [1:0] pat, input int delay, input int busy_cycles,
                        input logic [7:0] rd, input logic nk);
    int   win_len;
    int   last;
    bit   to;
    logic winner;
    win_len = use16 ? 16 : 64;
    winner  = (pat == 2'b11) ? ~model_lg : pat[1];
    to      = (delay >= win_len);
    last    = to ? win_len - 1 : delay;
    req_valid = pat;
    req_addr  = {f_addr[1], f_addr[0]};
    req_rw    = {f_rw[1], f_rw[0]};
    req_wdata = {f_wdata[1], f_wdata[0]};
    m_busy    = (busy_cycles > 0);
    for (int b = 0; b < busy_cycles; b++) begin
      @(negedge clk);
      check("busy_ready", o_ready, 2'b00);
      tick();
    end
    m_busy = 1'b0;
    @(negedge clk);
    check("grant_ready", o_ready, winner ? 2'b10 : 2'b01);
    check("idle_quiet", {o_done, o_to, o_start}, '0);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("issue_start", o_start, 1'b1);
    check("issue_fields", {o_addr, o_rw, o_wdata},
          {f_addr[winner], f_rw[winner], f_wdata[winner]});
    check("issue_ready", o_ready, 2'b00);
    for (int k = 0; k <= last; k++) begin
      tick();
      m_done  = (k == delay);
      m_rdata = (k == delay) ? rd : ~rd;
      m_nack  = (k == delay) ? nk : ~nk;
      @(negedge clk);
      check("wait_quiet", {o_done, o_to, o_start}, '0);
    end
    tick();
    m_done = 1'b0;
    @(negedge clk);
    check("resp_done", o_done, winner ? 2'b10 : 2'b01);
    check("resp_rdata", o_rdata, to ? 8'h00 : rd);
    check("resp_nack", o_nack, to ? 1'b1 : nk);
    check("resp_timeout", o_to, to);
    check("resp_fields", {o_addr, o_rw, o_wdata},
          {f_addr[winner], f_rw[winner], f_wdata[winner]});
    model_lg = winner;
    tick();
  endtask

  initial begin
    model_lg = 1'b1;
    tick();
    do_reset();

    // Single write from requester 0, completion after 20 WAIT cycles.
    rand_fields();
    f_addr[0] = 7'h65; f_rw[0] = 1'b0; f_wdata[0] = 8'hCA;
    do_txn(2'b01, 20, 0, 8'h00, 1'b0);

    // Three back-to-back ties after reset: req0, req1, req0.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      rand_fields();
      do_txn(2'b11, $urandom_range(0, 5), 0, 8'($urandom_range(0, 255)), 1'b0);
    end

    // Requester 1 read returning data with NACK.
    rand_fields();
    f_rw[1] = 1'b1;
    do_txn(2'b10, 5, 1, 8'h3C, 1'b1);

    // Timeout window of 16 on the second instance.
    do_reset();
    use16 = 1'b1;
    rand_fields();
    do_txn(2'b01, 100, 0, 8'h55, 1'b0);
    rand_fields();
    do_txn(2'b10, 4, 0, 8'hA7, 1'b0);
    rand_fields();
    do_txn(2'b11, 15, 0, 8'h99, 1'b1);
    rand_fields();
    do_txn(2'b11, 16, 0, 8'h11, 1'b0);
    rand_fields();
    do_txn(2'b01, 0, 0, 8'hE1, 1'b0);

    // Reset during WAIT abandons the transaction; busy then blocks grants.
    do_reset();
    use16 = 1'b0;
    rand_fields();
    req_valid = 2'b01;
    req_addr  = {f_addr[1], f_addr[0]};
    req_rw    = {f_rw[1], f_rw[0]};
    req_wdata = {f_wdata[1], f_wdata[0]};
    @(negedge clk);
    check("ab_ready", a_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    reset = 1'b1; m_busy = 1'b1; req_valid = 2'b01;
    @(negedge clk);
    check("ab_rst_out", {a_done, a_rdata, a_nack, a_to, a_start, a_ready}, '0);
    check("ab_rst_cmd", {a_addr, a_rw, a_wdata}, '0);
    tick();
    reset = 1'b0; m_done = 1'b1; m_rdata = 8'hFF; m_nack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("ab_busy_quiet", {a_done, a_to, a_start, a_ready}, '0);
      tick();
      m_done = 1'b0;
    end
    m_busy = 1'b0; req_valid = 2'b00; m_done = 1'b1;
    @(negedge clk);
    check("idle_mdone_ignored", {a_done, a_to, a_start, a_ready}, '0);
    tick();
    m_done = 1'b0;
    @(negedge clk);
    check("idle_mdone_after", {a_done, a_to, a_start}, '0);
    tick();
    model_lg = 1'b1;
    rand_fields();
    do_txn(2'b11, 3, 0, 8'h42, 1'b0);

    // Randomized traffic on the 64-cycle instance, including timeouts.
    for (int t = 0; t < 20; t++) begin
      rand_fields();
      do_txn(2'($urandom_range(1, 3)), $urandom_range(0, 70), $urandom_range(0, 3),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
